// File: rtl/xalu_pkg.sv
// xalu_pkg: shared opcode selects, default tag width and response-entry type for the ISE sequencer
package xalu_pkg;
  localparam logic [1:0] CUSTOM_0 = 2'd0;
  localparam logic [1:0] CUSTOM_1 = 2'd1;
  localparam logic [1:0] CUSTOM_2 = 2'd2;
  localparam logic [1:0] CUSTOM_3 = 2'd3;
  localparam int TAG_W_DEF = 5;
  // Tag field is sized for the widest supported tag; narrower tags are zero-extended on push.
  localparam int TAG_MAX_W = 16;
  typedef struct packed {
    logic [63:0]          data;
    logic [TAG_MAX_W-1:0] tag;
    logic                 illegal;
  } rsp_t;
endpackage

// File: rtl/xalu_rsp_fifo.sv
// xalu_rsp_fifo: power-of-two response FIFO with wrap-bit pointers and no fall-through
module xalu_rsp_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_full,
  output logic o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] r_wptr, r_rptr;
  T            r_mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      r_wptr <= r_wptr + {{AW{1'b0}}, i_push};
      r_rptr <= r_rptr + {{AW{1'b0}}, i_pop};
    end
  // Storage is written only; a push when full always coincides with a pop of the same slot.
  always_ff @(posedge i_clk)
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  assign o_data  = r_mem[r_rptr[AW-1:0]];
  assign o_empty = r_wptr == r_rptr;
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
endmodule

// File: rtl/xalu_ise_seq.sv
// xalu_ise_seq: request stage + response FIFO around an external ISE datapath; XALU_ISE_SEQ_ILLEGAL_EN enables illegal-op flagging
module xalu_ise_seq
  import xalu_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF,
  parameter int DEPTH = 2
) (
  input  logic             ise_clk,
  input  logic             ise_rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_fn,
  input  logic [6:0]       req_imm,
  input  logic [63:0]      req_in1,
  input  logic [63:0]      req_in2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             ise_val,
  output logic [5:0]       ise_fn,
  output logic [6:0]       ise_imm,
  output logic [63:0]      ise_in1,
  output logic [63:0]      ise_in2,
  input  logic             ise_oval,
  input  logic [63:0]      ise_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_illegal
);
  logic             r_val;
  logic [5:0]       r_fn;
  logic [6:0]       r_imm;
  logic [63:0]      r_in1, r_in2;
  logic [TAG_W-1:0] r_tag;
  logic             w_full, w_empty, w_pop, w_drain, w_acc, w_unused;
  rsp_t             w_push_d, w_head;
  assign w_pop     = rsp_valid & rsp_ready;
  assign w_drain   = r_val & (!w_full | w_pop);
  assign req_ready = !ise_rst & (!r_val | w_drain);
  assign w_acc     = req_valid & req_ready;
  // Request-stage valid: set on accept, cleared when drained with nothing new behind it.
  always_ff @(posedge ise_clk or posedge ise_rst)
    if (ise_rst) r_val <= 1'b0;
    else if (w_acc | w_drain) r_val <= w_acc;
  // Request-stage payload; qualified by r_val so it needs no reset.
  always_ff @(posedge ise_clk)
    if (w_acc) begin
      r_fn  <= req_fn;
      r_imm <= req_imm;
      r_in1 <= req_in1;
      r_in2 <= req_in2;
      r_tag <= req_tag;
    end
  assign ise_val = r_val;
  assign ise_fn  = r_fn;
  assign ise_imm = r_imm;
  assign ise_in1 = r_in1;
  assign ise_in2 = r_in2;
`ifdef XALU_ISE_SEQ_ILLEGAL_EN
  assign w_push_d    = '{data: ise_oval ? ise_out : 64'd0, tag: TAG_MAX_W'(r_tag), illegal: !ise_oval};
  assign rsp_illegal = w_head.illegal & rsp_valid;
  assign w_unused    = ^w_head;
`else
  assign w_push_d    = '{data: ise_out, tag: TAG_MAX_W'(r_tag), illegal: 1'b0};
  assign rsp_illegal = 1'b0;
  assign w_unused    = ^{ise_oval, w_head};
`endif
  xalu_rsp_fifo #(.DEPTH(DEPTH), .T(rsp_t)) u_fifo (
    .i_clk  (ise_clk),
    .i_rst  (ise_rst),
    .i_push (w_drain),
    .i_data (w_push_d),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );
  assign rsp_valid = !w_empty;
  assign rsp_data  = w_head.data;
  assign rsp_tag   = w_head.tag[TAG_W-1:0];
endmodule

// File: tb/tb_xalu_ise_seq.sv
// tb_xalu_ise_seq: scoreboard bench for the ISE sequencer with a small datapath model
module tb_xalu_ise_seq;
  import xalu_pkg::*;
  localparam int TAG_W = 5;
  localparam int DEPTH = 2;
`ifdef XALU_ISE_SEQ_ILLEGAL_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, rsp_illegal;
  logic [5:0] req_fn = '0, ise_fn;
  logic [6:0] req_imm = '0, ise_imm;
  logic [63:0] req_in1 = '0, req_in2 = '0, ise_in1, ise_in2, ise_out, rsp_data;
  logic [TAG_W-1:0] req_tag = '0, rsp_tag;
  logic ise_val, ise_oval;
  typedef struct { logic [63:0] data; logic [TAG_W-1:0] tag; logic ill; } exp_t;
  exp_t sb[$];
  exp_t e_mon;
  int n_cmp = 0, n_bad = 0;

  xalu_ise_seq #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .ise_clk(clk), .ise_rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_fn(req_fn), .req_imm(req_imm),
    .req_in1(req_in1), .req_in2(req_in2), .req_tag(req_tag),
    .ise_val(ise_val), .ise_fn(ise_fn), .ise_imm(ise_imm), .ise_in1(ise_in1), .ise_in2(ise_in2),
    .ise_oval(ise_oval), .ise_out(ise_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_illegal(rsp_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_out(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b);
    return f == CUSTOM_0 ? a + b : f == CUSTOM_1 ? a & b : f == CUSTOM_2 ? a ^ b : 64'd0;
  endfunction

  // External ISE datapath: CUSTOM_3 is unimplemented and reports no valid result.
  always_comb begin
    ise_oval = ise_val && ise_fn[1:0] != CUSTOM_3;
    ise_out  = ise_val ? model_out(ise_fn[1:0], ise_in1, ise_in2) : 64'd0;
  end

  // Scoreboard: compare on pop, record on accept, both sampled mid-cycle.
  always @(negedge clk) if (!rst) begin
    if (rsp_valid && rsp_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_unexpected: got tag %0d, required no response", rsp_tag);
      end else begin
        e_mon = sb.pop_front();
        if (rsp_data !== e_mon.data || rsp_tag !== e_mon.tag || rsp_illegal !== e_mon.ill) begin
          n_bad++;
          $display("FAIL rsp_order: got data=%h tag=%0d ill=%b, required data=%h tag=%0d ill=%b",
                   rsp_data, rsp_tag, rsp_illegal, e_mon.data, e_mon.tag, e_mon.ill);
        end
      end
    end
    if (req_valid && req_ready)
      sb.push_back('{model_out(req_fn[1:0], req_in1, req_in2), req_tag, ILL_EN && req_fn[1:0] == CUSTOM_3});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [1:0] f, input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] t);
    req_valid = v;
    req_fn    = {4'b0, f};
    req_imm   = 7'h44;
    req_in1   = a;
    req_in2   = b;
    req_tag   = t;
  endtask

  task automatic fill(input int n, input int tag0, output int acc);
    acc = 0;
    for (int c = 0; c < 20 && acc < n; c++) begin
      set_req(1'b1, 2'(acc % 3), 64'(acc) * 3, ~64'(acc), TAG_W'(tag0 + acc));
      @(negedge clk);
      if (req_ready) acc++;
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 30 && sb.size() != 0; c++) tick();
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL %s_drain: got %0d outstanding, required 0", name, sb.size()); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_cmp += 4;
    if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_req_ready: got %b, required 0", req_ready); end
    if (ise_val !== 1'b0) begin n_bad++; $display("FAIL rst_ise_val: got %b, required 0", ise_val); end
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b, required 0", rsp_valid); end
    if (rsp_illegal !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_illegal: got %b, required 0", rsp_illegal); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b, required 1", req_ready); end
  endtask

  task automatic test_single();
    rsp_ready = 1'b0;
    set_req(1'b1, CUSTOM_1, 64'h10, 64'hFFFF_FFFF_FFFF_FF00, TAG_W'(3));
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL single_accept: got %b, required 1", req_ready); end
    tick();
    req_valid = 1'b0;
    n_cmp += 2;
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_early: got rsp_valid %b, required 0", rsp_valid); end
    if (ise_val !== 1'b1 || ise_imm !== 7'h44) begin n_bad++; $display("FAIL single_s1: got val=%b imm=%h, required 1/44", ise_val, ise_imm); end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_data !== 64'd0 || rsp_tag !== TAG_W'(3) || rsp_illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL single_head: got v=%b data=%h tag=%0d ill=%b, required 1/0/3/0", rsp_valid, rsp_data, rsp_tag, rsp_illegal);
    end
    rsp_ready = 1'b1;
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_pop: got rsp_valid %b, required 0", rsp_valid); end
  endtask

  task automatic test_stream();
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, 2'(i % 3), {$urandom, $urandom}, {$urandom, $urandom}, TAG_W'(i));
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1) begin n_bad++; $display("FAIL stream_ready_%0d: got %b, required 1", i, req_ready); end
      tick();
    end
    req_valid = 1'b0;
    n_cmp++;
    if (sb.size() != 2) begin n_bad++; $display("FAIL stream_inflight: got %0d, required 2", sb.size()); end
    repeat (2) tick();
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL stream_rate: got %0d outstanding, required 0", sb.size()); end
  endtask

  task automatic test_backpressure();
    int acc;
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      set_req(acc < 4, 2'(acc % 3), 64'(acc) * 3, ~64'(acc), TAG_W'(10 + acc));
      @(negedge clk);
      if (req_valid && req_ready) acc++;
      tick();
    end
    n_cmp += 3;
    if (acc != DEPTH + 1) begin n_bad++; $display("FAIL bp_accepted: got %0d, required %0d", acc, DEPTH + 1); end
    if (req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready: got %b, required 0", req_ready); end
    if (ise_val !== 1'b1 || rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_held: got ise_val=%b rsp_valid=%b, required 1/1", ise_val, rsp_valid); end
    rsp_ready = 1'b1;
    for (int c = 0; c < 20 && acc < 4; c++) begin
      set_req(1'b1, 2'(acc % 3), 64'(acc) * 3, ~64'(acc), TAG_W'(10 + acc));
      @(negedge clk);
      if (req_ready) acc++;
      tick();
    end
    req_valid = 1'b0;
    drain("bp");
  endtask

  task automatic test_full_pushpop();
    int acc;
    rsp_ready = 1'b0;
    fill(DEPTH + 1, 20, acc);
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_req(1'b1, 2'(i % 3), {$urandom, $urandom}, {$urandom, $urandom}, TAG_W'(24 + i));
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 1'b1) begin n_bad++; $display("FAIL full_ready_%0d: got %b, required 1", i, req_ready); end
      tick();
      n_cmp++;
      if (sb.size() != DEPTH + 1) begin n_bad++; $display("FAIL full_occupancy_%0d: got %0d, required %0d", i, sb.size(), DEPTH + 1); end
    end
    req_valid = 1'b0;
    drain("full");
  endtask

  task automatic test_illegal();
    logic [63:0] d;
    rsp_ready = 1'b0;
    set_req(1'b1, CUSTOM_3, {$urandom, $urandom}, {$urandom, $urandom}, TAG_W'(9));
    tick();
    req_valid = 1'b0;
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_illegal !== ILL_EN || rsp_data !== 64'd0 || rsp_tag !== TAG_W'(9)) begin
      n_bad++;
      $display("FAIL illegal_head: got v=%b ill=%b data=%h tag=%0d, required 1/%b/0/9", rsp_valid, rsp_illegal, rsp_data, rsp_tag, ILL_EN);
    end
    d = rsp_data;
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_tag !== TAG_W'(9)) begin
      n_bad++;
      $display("FAIL illegal_hold: got v=%b data=%h tag=%0d, required 1/%h/9", rsp_valid, rsp_data, rsp_tag, d);
    end
    rsp_ready = 1'b1;
    drain("illegal");
  endtask

  task automatic test_reset_mid();
    int acc;
    rsp_ready = 1'b0;
    fill(3, 4, acc);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    n_cmp += 2;
    if (rsp_valid !== 1'b0 || rsp_illegal !== 1'b0) begin n_bad++; $display("FAIL mid_rst_rsp: got v=%b ill=%b, required 0/0", rsp_valid, rsp_illegal); end
    if (req_ready !== 1'b0 || ise_val !== 1'b0) begin n_bad++; $display("FAIL mid_rst_req: got ready=%b ise_val=%b, required 0/0", req_ready, ise_val); end
    repeat (2) tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_release_ready: got %b, required 1", req_ready); end
    rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL mid_stale_%0d: got rsp_valid %b, required 0", c, rsp_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_full_pushpop();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000, required completion");
    $fatal(1, "watchdog");
  end
endmodule
